uart_rx_deserializer: RTL



---
 rtl/uart_rx_deserializer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: sync, frame decode, parity/frame/break check.
// Ports: Clk, Rst (async low), Rx, FIFO_Full -> RTS, Rx_Data, Rx_Valid, Rx_Error[2:0], Overrun, Busy.
module uart_rx_deserializer #(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_BIT  = 1,
   parameter int STOP_BITS   = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Rx,
   input  logic                 FIFO_Full,
   output logic                 RTS,
   output logic [DATA_BITS-1:0] Rx_Data,
   output logic                 Rx_Valid,
   output logic [2:0]           Rx_Error,
   output logic                 Overrun,
   output logic                 Busy
);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   all_zero_q, all_zero_d;
   logic                   par_err_q, par_err_d;
   logic                   frm_err_q, frm_err_d;
   logic                   rx_valid_q, rx_valid_d;
   logic [2:0]             rx_error_q, rx_error_d;
   logic                   overrun_q, overrun_d;
   logic                   rts_q, rts_d;
   logic                   rx_s;
   logic                   az_n, fe_n;

   assign rx_s     = sync_q[SYNC_STAGES-1];
   assign sync_d   = {sync_q[SYNC_STAGES-2:0], Rx};
   assign rts_d    = !FIFO_Full && (state_q != BREAK_WAIT);

   assign RTS      = rts_q;
   assign Rx_Data  = rx_data_q;
   assign Rx_Valid = rx_valid_q;
   assign Rx_Error = rx_error_q;
   assign Overrun  = overrun_q;
   assign Busy     = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      all_zero_d = all_zero_q;
      par_err_d  = par_err_q;
      frm_err_d  = frm_err_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_error_d = rx_error_q;
      overrun_d  = 1'b0;
      az_n       = all_zero_q & ~rx_s;
      fe_n       = frm_err_q | ~rx_s;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d    = DATA;
               cnt_d      = 4'd0;
               all_zero_d = 1'b1;
               par_err_d  = 1'b0;
               frm_err_d  = 1'b0;
            end
         end
         DATA: begin
            // MSB-first: earliest bit ends up in the top position
            shift_d    = (shift_q << 1) | DATA_BITS'(rx_s);
            all_zero_d = az_n;
            if (cnt_q == 4'(DATA_BITS - 1)) begin
               cnt_d   = 4'd0;
               state_d = (PARITY_BIT != 0) ? PARITY : STOP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         PARITY: begin
            par_err_d  = (^shift_q) ^ rx_s;
            all_zero_d = az_n;
            cnt_d      = 4'd0;
            state_d    = STOP;
         end
         STOP: begin
            all_zero_d = az_n;
            frm_err_d  = fe_n;
            if (cnt_q == 4'(STOP_BITS - 1)) begin
               // Completion decided now; registered results show next cycle
               if (az_n) begin
                  rx_error_d = 3'b001;
                  state_d    = BREAK_WAIT;
               end else begin
                  rx_error_d = {fe_n, par_err_q, 1'b0};
                  state_d    = IDLE;
                  if (!FIFO_Full) begin
                     rx_valid_d = 1'b1;
                     rx_data_d  = shift_q;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         BREAK_WAIT: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= IDLE;
         sync_q     <= '1;
         cnt_q      <= 4'd0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         all_zero_q <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_error_q <= 3'b000;
         overrun_q  <= 1'b0;
         rts_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         all_zero_q <= all_zero_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
         rx_valid_q <= rx_valid_d;
         rx_error_q <= rx_error_d;
         overrun_q  <= overrun_d;
         rts_q      <= rts_d;
      end
   end

endmodule
